// File: rtl/reg_file_pkg.sv
// Shared constants for the parametrised register file.
// Default geometry used by the top and its decoder.
package reg_file_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/n_to_onehot_decoder.sv
// Binary address to one-hot select decoder.
// All outputs are zero while en is low.
module n_to_onehot_decoder
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] onehot
);

  // one bit per entry, set only for the enabled address
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/param_reg_file.sv
// Flip-flop register file: one write port, two registered
// read ports with write-through bypass and bulk clear.
module param_reg_file
  import reg_file_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic              re,
  input  logic [ADDR_W-1:0] rAddr0,
  input  logic [ADDR_W-1:0] rAddr1,
  output logic [DATA_W-1:0] rData0,
  output logic [DATA_W-1:0] rData1,
  output logic              rValid
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit Z0    = (ZERO_R0 != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  wsel;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;

  n_to_onehot_decoder #(
    .ADDR_W(ADDR_W)
  ) u_dec (
    .en    (we),
    .addr  (wAddr),
    .onehot(wsel)
  );

  // entry storage: reset/clear zero everything, else selected entry loads
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wsel[i] && !(Z0 && i == 0)) mem[i] <= wData;
    end
  end

  // port 0 read value: clear and hard-wired r0 force zero, else bypass
  always_comb begin
    rd0 = mem[rAddr0];
    if (we && rAddr0 == wAddr) rd0 = wData;
    if (clear || (Z0 && rAddr0 == '0)) rd0 = '0;
  end

  // port 1 read value, same rules as port 0
  always_comb begin
    rd1 = mem[rAddr1];
    if (we && rAddr1 == wAddr) rd1 = wData;
    if (clear || (Z0 && rAddr1 == '0)) rd1 = '0;
  end

  // registered read outputs; data holds when re is low
  always_ff @(posedge clk) begin
    if (reset) begin
      rData0 <= '0;
      rData1 <= '0;
      rValid <= 1'b0;
    end else begin
      rValid <= re;
      if (re) begin
        rData0 <= rd0;
        rData1 <= rd1;
      end
    end
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench: two register files (plain and zero-r0)
// share stimulus; a monitor pops expected reads each cycle.
module tb_param_reg_file;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int N  = 2**AW;

  typedef struct {
    logic          v;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, clear, we, re;
  logic [AW-1:0] wAddr, rAddr0, rAddr1;
  logic [DW-1:0] wData;
  logic [DW-1:0] a_d0, a_d1, b_d0, b_d1;
  logic          a_v, b_v;

  int passed = 0;
  int total  = 0;

  exp_t qa[$];
  exp_t qb[$];

  logic [DW-1:0] m   [2][N];
  logic [DW-1:0] o0  [2];
  logic [DW-1:0] o1  [2];
  logic [N-1:0]  exp_sel;

  always #5 clk = ~clk;

  param_reg_file #(.ADDR_W(AW), .DATA_W(DW), .ZERO_R0(0)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .we(we),
    .wAddr(wAddr), .wData(wData), .re(re),
    .rAddr0(rAddr0), .rAddr1(rAddr1),
    .rData0(a_d0), .rData1(a_d1), .rValid(a_v)
  );

  param_reg_file #(.ADDR_W(AW), .DATA_W(DW), .ZERO_R0(1)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .we(we),
    .wAddr(wAddr), .wData(wData), .re(re),
    .rAddr0(rAddr0), .rAddr1(rAddr1),
    .rData0(b_d0), .rData1(b_d1), .rValid(b_v)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] rd_val(int k, logic [AW-1:0] a);
    if (clear) return '0;
    if (k == 1 && a == 0) return '0;
    if (we && a == wAddr) return wData;
    return m[k][a];
  endfunction

  // apply one cycle of stimulus and push the model's expectation
  task automatic drive(logic rs, logic cl, logic w, int wa,
                       logic [DW-1:0] wd, logic r, int a0, int a1);
    exp_t e;
    @(negedge clk);
    reset = rs; clear = cl; we = w; wAddr = AW'(wa);
    wData = wd; re = r; rAddr0 = AW'(a0); rAddr1 = AW'(a1);
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        o0[k] = '0; o1[k] = '0; e.v = 1'b0;
        for (int i = 0; i < N; i++) m[k][i] = '0;
      end else begin
        e.v = r;
        if (r) begin
          o0[k] = rd_val(k, rAddr0);
          o1[k] = rd_val(k, rAddr1);
        end
        if (cl) begin
          for (int i = 0; i < N; i++) m[k][i] = '0;
        end else if (w && !(k == 1 && wa == 0)) begin
          m[k][wa] = wd;
        end
      end
      e.d0 = o0[k]; e.d1 = o1[k];
      if (k == 0) qa.push_back(e);
      else qb.push_back(e);
    end
  endtask

  // monitor: after every edge compare outputs against queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    exp_sel = we ? (N'(1) << wAddr) : '0;
    if (qa.size() > 0) begin
      chk("decoder_onehot", 64'(dut_a.wsel), 64'(exp_sel));
      e = qa.pop_front();
      chk("a_valid", 64'(a_v), 64'(e.v));
      chk("a_rdata0", 64'(a_d0), 64'(e.d0));
      chk("a_rdata1", 64'(a_d1), 64'(e.d1));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_valid", 64'(b_v), 64'(e.v));
      chk("b_rdata0", 64'(b_d0), 64'(e.d0));
      chk("b_rdata1", 64'(b_d1), 64'(e.d1));
    end
  end

  initial begin
    reset = 1'b0; clear = 1'b0; we = 1'b0; re = 1'b0;
    wAddr = '0; rAddr0 = '0; rAddr1 = '0; wData = '0;

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 2, 32'h1, 1, 2, 2);
    // basic write then read
    drive(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 5, 5);
    // bypass on port 0, stored value on port 1
    drive(0, 0, 1, 2, 32'hAA, 0, 0, 0);
    drive(0, 0, 1, 3, 32'h12345678, 1, 3, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // hard-wired zero entry on the ZERO_R0 instance
    drive(0, 0, 1, 0, 32'hFFFF, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 32'h1234, 1, 0, 0);
    // fill, then clear with simultaneous write and read
    for (int i = 0; i < N; i++)
      drive(0, 0, 1, i, 32'h100 + i, 0, 0, 0);
    drive(0, 1, 1, 1, 32'hBEEF, 1, 1, 7);
    for (int i = 0; i < N; i++)
      drive(0, 0, 0, 0, 0, 1, i, N - 1 - i);
    // reset swallows the pending read
    drive(0, 0, 1, 4, 32'h55, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 4, 4);
    drive(0, 0, 0, 0, 0, 1, 4, 4);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 29) == 0),
            1'($urandom), $urandom_range(0, N - 1), $urandom,
            1'($urandom), $urandom_range(0, N - 1),
            $urandom_range(0, N - 1));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++)
      @(negedge clk);
    total++;
    if (qa.size() == 0 && qb.size() == 0) passed++;
    else $display("FAIL drain: %0d/%0d entries left, expected 0",
                  qa.size(), qb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
